// File: rtl/wimax_deinterleaver_pkg.sv
// Shared constants, bank state encoding and golden vectors for the WiMAX QPSK block deinterleaver.
// INTERLEAVER_OUTPUT is derived from FEC_ENDODER_OUTPUT so the two vectors always stay consistent.
package wimax_deinterleaver_pkg;

   localparam int NCBPS_QPSK       = 192;
   localparam int INTERLEAVER_D    = 16;
   localparam int INTERLEAVER_ROWS = NCBPS_QPSK / INTERLEAVER_D;

   typedef enum logic [1:0] {
      BANK_EMPTY   = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_FULL    = 2'd2
   } bank_state_t;

   // Bit [NCBPS-1] of each vector is the first bit in time.
   localparam logic [NCBPS_QPSK-1:0] FEC_ENDODER_OUTPUT =
      192'h3A5F_0C96_E1B7_24D8_9F06_5BC3_7E12_A4F9_D05C_8B63_17EA_42BD;

   // Over-the-air order: received bit j carries encoder bit k = D*(j mod ROWS) + j/ROWS.
   function automatic logic [NCBPS_QPSK-1:0] interleave_block(input logic [NCBPS_QPSK-1:0] src);
      logic [NCBPS_QPSK-1:0] dst;
      dst = '0;
      for (int j = 0; j < NCBPS_QPSK; j++) begin
         int k;
         k = INTERLEAVER_D * (j % INTERLEAVER_ROWS) + j / INTERLEAVER_ROWS;
         dst[NCBPS_QPSK-1-j] = src[NCBPS_QPSK-1-k];
      end
      return dst;
   endfunction

   localparam logic [NCBPS_QPSK-1:0] INTERLEAVER_OUTPUT = interleave_block(FEC_ENDODER_OUTPUT);

endpackage

// File: rtl/deinterleaver_bank.sv
// One NCBPS-bit block buffer: single-bit write port, single-bit read port, synchronous clear.
// A write in the same cycle as a clear wins, so the bank can be refilled right after draining.
module deinterleaver_bank
   import wimax_deinterleaver_pkg::*;
#(
   parameter  int NCBPS = NCBPS_QPSK,
   localparam int AW    = $clog2(NCBPS)
) (
   input  logic          clk,
   input  logic          reset_N,
   input  logic          clear_i,
   input  logic          we_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic          wr_data_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic          rd_data_o
);

   logic [NCBPS-1:0] mem_q;

   // NOTE: the storage is real flops with a reset, not a RAM macro, so it can be cleared on reset_N.
   always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) begin
         mem_q <= '0;
      end else if (we_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end else if (clear_i) begin
         mem_q <= '0;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/wimax_deinterleaver.sv
// WiMAX QPSK block deinterleaver: ping-pong banks, row-major writes at D*r+c, sequential reads.
// Writing received bit j to address D*(j mod ROWS)+j/ROWS lets the read side simply count 0..NCBPS-1.
module wimax_deinterleaver
   import wimax_deinterleaver_pkg::*;
#(
   parameter int NCBPS = NCBPS_QPSK,
   parameter int D     = INTERLEAVER_D
) (
   input  logic clk,
   input  logic reset_N,
   input  logic data_in,
   input  logic valid_in,
   output logic ready_out,
   output logic data_out,
   output logic valid_out,
   input  logic ready_in
);

   localparam int ROWS = NCBPS / D;
   localparam int AW   = $clog2(NCBPS);
   localparam int RW   = $clog2(ROWS);
   localparam int DW   = $clog2(D);

   logic [RW-1:0] r_q, r_d;
   logic [DW-1:0] c_q, c_d;
   logic [AW-1:0] rd_idx_q, rd_idx_d;
   logic          wr_bank_q, wr_bank_d;
   logic          rd_bank_q, rd_bank_d;
   bank_state_t   state_q [2];
   bank_state_t   state_d [2];

   logic          accept, consume, wr_last, rd_last;
   logic [AW-1:0] wr_addr;
   logic          rd_bit [2];

   // D is a power of two, so D*r + c is just {r, c}.
   assign wr_addr = AW'({r_q, c_q});

   always_comb begin
      ready_out = (state_q[wr_bank_q] != BANK_FULL);
      valid_out = (state_q[rd_bank_q] == BANK_FULL);
      accept    = valid_in && ready_out;
      consume   = valid_out && ready_in;
      wr_last   = accept && (r_q == RW'(ROWS-1)) && (c_q == DW'(D-1));
      rd_last   = consume && (rd_idx_q == AW'(NCBPS-1));
      data_out  = rd_bit[rd_bank_q];
   end

   // NOTE: every variable driven here gets its hold value first, so no path can infer a latch.
   always_comb begin
      r_d       = r_q;
      c_d       = c_q;
      wr_bank_d = wr_bank_q;
      rd_idx_d  = rd_idx_q;
      rd_bank_d = rd_bank_q;
      state_d   = state_q;

      if (accept) begin
         state_d[wr_bank_q] = wr_last ? BANK_FULL : BANK_FILLING;
         if (r_q == RW'(ROWS-1)) begin
            r_d = '0;
            c_d = (c_q == DW'(D-1)) ? '0 : c_q + 1'b1;
         end else begin
            r_d = r_q + 1'b1;
         end
         if (wr_last) begin
            wr_bank_d = ~wr_bank_q;
         end
      end

      // A write only targets a non-FULL bank and a read only drains a FULL one,
      // so both updates can land on the same edge without colliding.
      if (consume) begin
         rd_idx_d = rd_last ? '0 : rd_idx_q + 1'b1;
         if (rd_last) begin
            state_d[rd_bank_q] = BANK_EMPTY;
            rd_bank_d          = ~rd_bank_q;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) begin
         r_q       <= '0;
         c_q       <= '0;
         rd_idx_q  <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         state_q   <= '{default: BANK_EMPTY};
      end else begin
         r_q       <= r_d;
         c_q       <= c_d;
         rd_idx_q  <= rd_idx_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         state_q   <= state_d;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      deinterleaver_bank #(
         .NCBPS (NCBPS)
      ) u_bank (
         .clk       (clk),
         .reset_N   (reset_N),
         .clear_i   (rd_last && (rd_bank_q == 1'(b))),
         .we_i      (accept && (wr_bank_q == 1'(b))),
         .wr_addr_i (wr_addr),
         .wr_data_i (data_in),
         .rd_addr_i (rd_idx_q),
         .rd_data_o (rd_bit[b])
      );
   end

endmodule
